// File: rtl/cache_control_nway_if.sv
// rtl/cache_control_nway_if.sv - CPU, datapath and memory signals of the N-way cache controller
interface cache_control_nway_if #(
  parameter int WAYS      = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  // CPU request side
  logic              mem_read;
  logic              mem_write;
  logic              mem_resp;

  // Datapath status of the addressed set
  logic [WAYS-1:0]   hit_vec;
  logic [WAYS-1:0]   valid_vec;
  logic [WAYS-1:0]   dirty_vec;
  logic [WAY_W-1:0]  plru_victim;

  // Datapath controls
  logic [WAY_W-1:0]  way_sel;
  logic              load_cache;
  logic              load_tag;
  logic              load_dirty;
  logic              dirty_val;
  logic              load_lru;
  logic              source_sel;
  logic              addrmux_sel;
  logic              tag_sel;
  logic [BEAT_W-1:0] beat_idx;

  // Memory burst port
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_ready;

  // Statistics and error
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  logic              multi_hit_err;

  // Environment side: CPU, datapath arrays and memory
  modport master (
    output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_victim, pmem_ready,
    input  mem_resp, way_sel, load_cache, load_tag, load_dirty, dirty_val, load_lru,
           source_sel, addrmux_sel, tag_sel, beat_idx, pmem_read, pmem_write,
           hit_count, miss_count, multi_hit_err
  );

  // Controller side
  modport slave (
    input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_victim, pmem_ready,
    output mem_resp, way_sel, load_cache, load_tag, load_dirty, dirty_val, load_lru,
           source_sel, addrmux_sel, tag_sel, beat_idx, pmem_read, pmem_write,
           hit_count, miss_count, multi_hit_err
  );
endinterface

// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - control FSM for an N-way write-back write-allocate cache
module cache_control_nway #(
  parameter int WAYS      = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  cache_control_nway_if.slave bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, INSTALL, RESPOND} state_t;

  state_t            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              write_q, write_d;
  logic              hit_inc, miss_inc, multi_set;
  logic [WAY_W-1:0]  hit_way, inv_way;
  logic              inv_any;

  assign bus.beat_idx = beat_q;

  // Lowest matching way and lowest invalid way; scanning downward lets the lowest index win
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    inv_any = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit_vec[i]) hit_way = WAY_W'(i);
      if (!bus.valid_vec[i]) begin
        inv_way = WAY_W'(i);
        inv_any = 1'b1;
      end
    end
  end

  // State, victim, beat counter and latched write flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      beat_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      write_q  <= write_d;
    end
  end

  // Saturating statistics and the sticky multiple-hit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hit_count     <= '0;
      bus.miss_count    <= '0;
      bus.multi_hit_err <= 1'b0;
    end else begin
      if (hit_inc && (bus.hit_count != '1)) bus.hit_count <= bus.hit_count + 1'b1;
      if (miss_inc && (bus.miss_count != '1)) bus.miss_count <= bus.miss_count + 1'b1;
      if (multi_set) bus.multi_hit_err <= 1'b1;
    end
  end

  // Next-state and datapath/memory strobes
  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    beat_d          = beat_q;
    write_d         = write_q;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    multi_set       = 1'b0;
    bus.mem_resp    = 1'b0;
    bus.way_sel     = '0;
    bus.load_cache  = 1'b0;
    bus.load_tag    = 1'b0;
    bus.load_dirty  = 1'b0;
    bus.dirty_val   = 1'b0;
    bus.load_lru    = 1'b0;
    bus.source_sel  = 1'b0;
    bus.addrmux_sel = 1'b1;
    bus.tag_sel     = 1'b1;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;

    case (state_q)
      IDLE: begin
        bus.addrmux_sel = 1'b0;
        if (bus.mem_read || bus.mem_write) state_d = LOOKUP;
      end
      LOOKUP: begin
        bus.way_sel = hit_way;
        multi_set   = |(bus.hit_vec & (bus.hit_vec - {{(WAYS-1){1'b0}}, 1'b1}));
        if (|bus.hit_vec) begin
          bus.mem_resp = 1'b1;
          bus.load_lru = 1'b1;
          hit_inc      = 1'b1;
          if (bus.mem_write) begin
            bus.load_cache = 1'b1;
            bus.load_dirty = 1'b1;
            bus.dirty_val  = 1'b1;
          end
          state_d = IDLE;
        end else begin
          // Write flag is latched so a request dropped mid-miss still completes correctly
          victim_d = inv_any ? inv_way : bus.plru_victim;
          write_d  = bus.mem_write;
          miss_inc = 1'b1;
          beat_d   = '0;
          if (bus.dirty_vec[victim_d] && bus.valid_vec[victim_d]) state_d = WRITEBACK;
          else                                                    state_d = FILL;
        end
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        bus.tag_sel    = 1'b0;
        bus.way_sel    = victim_q;
        if (bus.pmem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = victim_q;
        if (bus.pmem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = INSTALL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      INSTALL: begin
        bus.way_sel    = victim_q;
        bus.load_cache = 1'b1;
        bus.source_sel = 1'b1;
        bus.load_tag   = 1'b1;
        bus.load_dirty = 1'b1;
        bus.dirty_val  = 1'b0;
        state_d        = RESPOND;
      end
      RESPOND: begin
        bus.way_sel  = victim_q;
        bus.mem_resp = 1'b1;
        bus.load_lru = 1'b1;
        if (write_q) begin
          bus.load_cache = 1'b1;
          bus.load_dirty = 1'b1;
          bus.dirty_val  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_control_nway.sv
// tb/tb_cache_control_nway.sv - directed self-checking bench for cache_control_nway
module tb_cache_control_nway;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cache_control_nway_if #(.WAYS(4), .BURST_LEN(4), .CNT_W(2)) bus ();

  cache_control_nway #(.WAYS(4), .BURST_LEN(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at the current cycle and follow it to mem_resp
  task automatic run_req(input string tag, input bit rd, input bit wr, input bit stall,
                         input int exp_lat, input logic [1:0] exp_way, input bit exp_wr,
                         input int exp_wb, input int exp_fill);
    int n, fcnt, wbc, fc;
    bit got;
    n = 0; fcnt = 0; wbc = 0; fc = 0; got = 1'b0;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.pmem_ready = !stall;
    while (!got && n < 40) begin
      if (stall) bus.pmem_ready = bus.pmem_read && ((fcnt % 4) == 3);
      @(negedge clk);
      if (bus.pmem_write) begin
        wbc++;
        chk({tag, "_wb_tag_sel"}, 32'(bus.tag_sel), 32'd0);
      end
      if (bus.pmem_read) begin
        fc++;
        if (stall) begin
          chk({tag, "_stall_beat"}, 32'(bus.beat_idx), 32'(fcnt / 4));
          fcnt++;
        end
      end
      if (bus.pmem_read || bus.pmem_write) chk({tag, "_burst_way"}, 32'(bus.way_sel), 32'(exp_way));
      if (bus.load_tag) begin
        chk({tag, "_install_src"}, 32'(bus.source_sel), 32'd1);
        chk({tag, "_install_dv"}, 32'(bus.dirty_val), 32'd0);
        chk({tag, "_install_lc"}, 32'(bus.load_cache), 32'd1);
      end
      if (bus.mem_resp) begin
        got = 1'b1;
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_resp_way"}, 32'(bus.way_sel), 32'(exp_way));
        chk({tag, "_resp_lru"}, 32'(bus.load_lru), 32'd1);
        chk({tag, "_resp_load_cache"}, 32'(bus.load_cache), 32'(exp_wr));
        chk({tag, "_resp_dirty_val"}, 32'(bus.dirty_val), 32'(exp_wr));
      end else begin
        tick();
        n++;
      end
    end
    chk({tag, "_got_resp"}, 32'(got), 32'd1);
    chk({tag, "_wb_beats"}, 32'(wbc), 32'(exp_wb));
    chk({tag, "_fill_cycles"}, 32'(fc), 32'(exp_fill));
    tick();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.pmem_ready = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit_vec = 4'b0000;
    bus.valid_vec = 4'b1111;
    bus.dirty_vec = 4'b0000;
    bus.plru_victim = 2'd0;
    bus.pmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_resp", 32'(bus.mem_resp), 32'd0);
    chk("rst_pmem", 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
    chk("rst_loads", 32'({bus.load_cache, bus.load_tag, bus.load_dirty, bus.load_lru}), 32'd0);
    chk("rst_way_sel", 32'(bus.way_sel), 32'd0);
    chk("rst_addrmux", 32'(bus.addrmux_sel), 32'd0);
    chk("rst_tag_sel", 32'(bus.tag_sel), 32'd1);
    chk("rst_beat", 32'(bus.beat_idx), 32'd0);
    chk("rst_counts", 32'({bus.hit_count, bus.miss_count}), 32'd0);
    chk("rst_multi", 32'(bus.multi_hit_err), 32'd0);
    tick();

    // Read hit in way 2
    bus.hit_vec = 4'b0100;
    run_req("rd_hit", 1'b1, 1'b0, 1'b0, 1, 2'd2, 1'b0, 0, 0);
    chk("rd_hit_count", 32'(bus.hit_count), 32'd1);

    // Write miss, way 2 invalid, clean fill
    bus.hit_vec = 4'b0000;
    bus.valid_vec = 4'b1011;
    bus.dirty_vec = 4'b0000;
    bus.plru_victim = 2'd0;
    run_req("wr_miss", 1'b0, 1'b1, 1'b0, 7, 2'd2, 1'b1, 0, 4);
    chk("wr_miss_count", 32'(bus.miss_count), 32'd1);

    // Read miss, all valid, PLRU victim way 1 dirty -> writeback then fill
    bus.valid_vec = 4'b1111;
    bus.dirty_vec = 4'b0010;
    bus.plru_victim = 2'd1;
    run_req("dirty_miss", 1'b1, 1'b0, 1'b0, 11, 2'd1, 1'b0, 4, 4);
    chk("dirty_miss_count", 32'(bus.miss_count), 32'd2);

    // Clean read miss with three wait cycles per fill beat
    bus.dirty_vec = 4'b0000;
    bus.plru_victim = 2'd3;
    run_req("stall_miss", 1'b1, 1'b0, 1'b1, 19, 2'd3, 1'b0, 0, 16);
    chk("stall_miss_count", 32'(bus.miss_count), 32'd3);

    // Read and write both high is a write; miss counter saturates at 3
    bus.plru_victim = 2'd0;
    run_req("rw_miss", 1'b1, 1'b1, 1'b0, 7, 2'd0, 1'b1, 0, 4);
    chk("miss_count_sat", 32'(bus.miss_count), 32'd3);

    // Multiple hit bits: lowest way chosen, sticky error raised
    bus.hit_vec = 4'b0110;
    run_req("multi_hit", 1'b1, 1'b0, 1'b0, 1, 2'd1, 1'b0, 0, 0);
    chk("multi_err_set", 32'(bus.multi_hit_err), 32'd1);
    chk("multi_hit_count", 32'(bus.hit_count), 32'd2);

    // Write hit in way 0: error stays sticky, hit counter reaches 3 then saturates
    bus.hit_vec = 4'b0001;
    run_req("wr_hit", 1'b0, 1'b1, 1'b0, 1, 2'd0, 1'b1, 0, 0);
    chk("multi_err_sticky", 32'(bus.multi_hit_err), 32'd1);
    chk("wr_hit_count", 32'(bus.hit_count), 32'd3);
    run_req("rd_hit2", 1'b1, 1'b0, 1'b0, 1, 2'd0, 1'b0, 0, 0);
    chk("hit_count_sat", 32'(bus.hit_count), 32'd3);

    // Reset during writeback beat 2 abandons the miss
    bus.hit_vec = 4'b0000;
    bus.dirty_vec = 4'b0010;
    bus.plru_victim = 2'd1;
    bus.mem_read = 1'b1;
    bus.pmem_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("abort_pre_wb", 32'(bus.pmem_write), 32'd1);
    chk("abort_pre_beat", 32'(bus.beat_idx), 32'd2);
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.pmem_ready = 1'b0;
    tick();
    chk("abort_pmem_write", 32'(bus.pmem_write), 32'd0);
    chk("abort_pmem_read", 32'(bus.pmem_read), 32'd0);
    chk("abort_idle", 32'(bus.addrmux_sel), 32'd0);
    chk("abort_loads", 32'({bus.load_cache, bus.load_tag, bus.load_dirty}), 32'd0);
    chk("abort_counts", 32'({bus.hit_count, bus.miss_count}), 32'd0);
    chk("abort_multi", 32'(bus.multi_hit_err), 32'd0);
    chk("abort_beat", 32'(bus.beat_idx), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(bus.mem_resp), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
